hazard_ctrl: RTL and testbench

- Central pipeline hazard controller. Produces the stall and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Resolves four hazard classes: load-use interlock, CSR serialization, multi-cycle EX/MEM backpressure, and EX redirects (taken branch or jump).
- Sequences trap entry through a small FSM that holds the pipeline flushed for a programmable number of bubble cycles.
- Keeps free-running stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation for the five pipeline registers,
// trap-entry sequencing FSM and free-running stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned TRAP_BUBBLES = 1,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs1,
  input  logic             i_id_uses_rs2,
  input  logic             i_id_is_csr,
  input  logic             i_ex_valid,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_is_load,
  input  logic             i_ex_busy,
  input  logic             i_ex_redirect,
  input  logic             i_mem_valid,
  input  logic             i_mem_busy,
  input  logic             i_trap,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_flush,
  output logic             o_idex_stall,
  output logic             o_idex_flush,
  output logic             o_exmem_stall,
  output logic             o_exmem_flush,
  output logic             o_memwb_flush,
  output logic             o_trap_busy,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  typedef enum logic [1:0] {StRun, StFlush, StDrain} state_t;

  state_t           r_state;
  logic [3:0]       r_bub;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_load_use;
  logic w_csr_ser;
  logic w_redirect_evt;

  assign w_load_use = i_id_valid & i_ex_valid & i_ex_is_load & (i_ex_rd != 5'd0) &
                      ((i_id_uses_rs1 & (i_id_rs1 == i_ex_rd)) |
                       (i_id_uses_rs2 & (i_id_rs2 == i_ex_rd)));
  assign w_csr_ser  = i_id_valid & i_id_is_csr & (i_ex_valid | i_mem_valid);

  always_comb begin
    o_pc_stall     = 1'b0;
    o_ifid_stall   = 1'b0;
    o_ifid_flush   = 1'b0;
    o_idex_stall   = 1'b0;
    o_idex_flush   = 1'b0;
    o_exmem_stall  = 1'b0;
    o_exmem_flush  = 1'b0;
    o_memwb_flush  = 1'b0;
    w_redirect_evt = 1'b0;
    if (i_rst) begin
      o_ifid_flush  = 1'b1;
      o_idex_flush  = 1'b1;
      o_exmem_flush = 1'b1;
      o_memwb_flush = 1'b1;
    end else begin
      case (r_state)
        StFlush: begin
          o_ifid_flush  = 1'b1;
          o_idex_flush  = 1'b1;
          o_exmem_flush = 1'b1;
          o_memwb_flush = 1'b1;
        end
        StDrain: begin
          o_ifid_flush = 1'b1;
          o_idex_flush = 1'b1;
        end
        default: begin
          if (i_trap) begin
            o_ifid_flush  = 1'b1;
            o_idex_flush  = 1'b1;
            o_exmem_flush = 1'b1;
            o_memwb_flush = 1'b1;
          end else if (i_mem_busy) begin
            // EX is frozen here, so any concurrent redirect is presented again later
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
            o_memwb_flush = 1'b1;
          end else if (i_ex_busy) begin
            o_pc_stall    = 1'b1;
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_flush = 1'b1;
          end else if (i_ex_redirect & i_ex_valid) begin
            o_ifid_flush   = 1'b1;
            o_idex_flush   = 1'b1;
            w_redirect_evt = 1'b1;
          end else if (w_load_use | w_csr_ser) begin
            o_pc_stall   = 1'b1;
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StRun;
      r_bub       <= 4'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (i_trap) begin
        r_state <= StFlush;
      end else begin
        case (r_state)
          StFlush: begin
            r_bub   <= 4'(TRAP_BUBBLES);
            r_state <= StDrain;
          end
          StDrain: begin
            if (r_bub == 4'd1) r_state <= StRun;
            else               r_bub   <= r_bub - 4'd1;
          end
          default: r_state <= StRun;
        endcase
      end
      if (o_pc_stall)               r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (i_trap | w_redirect_evt)  r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign o_trap_busy = (r_state != StRun);
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int unsigned B  = 3;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid, id_uses_rs1, id_uses_rs2, id_is_csr;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          ex_valid, ex_is_load, ex_busy, ex_redirect;
  logic          mem_valid, mem_busy, trap;
  logic          pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic          exmem_stall, exmem_flush, memwb_flush, trap_busy;
  logic [CW-1:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.TRAP_BUBBLES(B), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
    .i_id_uses_rs1(id_uses_rs1), .i_id_uses_rs2(id_uses_rs2), .i_id_is_csr(id_is_csr),
    .i_ex_valid(ex_valid), .i_ex_rd(ex_rd), .i_ex_is_load(ex_is_load),
    .i_ex_busy(ex_busy), .i_ex_redirect(ex_redirect),
    .i_mem_valid(mem_valid), .i_mem_busy(mem_busy), .i_trap(trap),
    .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall), .o_ifid_flush(ifid_flush),
    .o_idex_stall(idex_stall), .o_idex_flush(idex_flush),
    .o_exmem_stall(exmem_stall), .o_exmem_flush(exmem_flush),
    .o_memwb_flush(memwb_flush), .o_trap_busy(trap_busy),
    .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles of trap activity still to come (B+1 = full-flush cycle, then drain).
  int          m_left  = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    rst = 0; trap = 0; mem_busy = 0; ex_busy = 0; ex_redirect = 0;
    id_valid = 0; id_uses_rs1 = 0; id_uses_rs2 = 0; id_is_csr = 0;
    id_rs1 = 0; id_rs2 = 0; ex_valid = 0; ex_rd = 0; ex_is_load = 0; mem_valid = 0;
  endtask

  // Inputs are already applied (after a negedge); check, then step model across posedge.
  task automatic cycle();
    int   depth;
    logic [3:0] fl;
    logic evt, lu, csr;
    logic [7:0] exp_ctl, got_ctl;
    #1;
    depth = 0; fl = 4'b0000; evt = 0;
    lu  = id_valid & ex_valid & ex_is_load & (ex_rd != 0) &
          ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    csr = id_valid & id_is_csr & (ex_valid | mem_valid);
    if (rst || m_left == int'(B) + 1) fl = 4'b1111;
    else if (m_left > 0)              fl = 4'b1100;
    else if (trap)                    fl = 4'b1111;
    else if (mem_busy)                begin depth = 4; fl = 4'b0001; end
    else if (ex_busy)                 begin depth = 3; fl = 4'b0010; end
    else if (ex_redirect && ex_valid) begin fl = 4'b1100; evt = 1; end
    else if (lu || csr)               begin depth = 2; fl = 4'b0100; end
    exp_ctl = {depth >= 1, depth >= 2, depth >= 3, depth >= 4, fl};
    got_ctl = {pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, exmem_flush, memwb_flush};
    check("ctl", 32'(got_ctl), 32'(exp_ctl));
    check("excl", 32'({ifid_stall & ifid_flush, idex_stall & idex_flush,
                       exmem_stall & exmem_flush}), 32'd0);
    check("busy", 32'(trap_busy), 32'(m_left > 0));
    check("stall_cnt", 32'(stall_cnt), m_stall);
    check("flush_cnt", 32'(flush_cnt), m_flush);
    @(posedge clk);
    if (rst) begin
      m_left = 0; m_stall = 0; m_flush = 0;
    end else begin
      m_stall = (m_stall + ((depth >= 1) ? 1 : 0)) % (1 << CW);
      m_flush = (m_flush + ((trap || evt) ? 1 : 0)) % (1 << CW);
      if (trap)            m_left = int'(B) + 1;
      else if (m_left > 0) m_left = m_left - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_idle(); rst = 1; cycle(); cycle(); rst = 0;
  endtask

  initial begin
    set_idle();
    rst = 1;
    @(negedge clk);
    do_reset();
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load-use on x5, then the same with rd=x0.
    ex_valid = 1; ex_is_load = 1; ex_rd = 5; id_valid = 1; id_uses_rs1 = 1; id_rs1 = 5;
    cycle();
    set_idle(); cycle();
    check("lu_one_stall", 32'(stall_cnt), 32'd1);
    ex_valid = 1; ex_is_load = 1; ex_rd = 0; id_valid = 1; id_uses_rs1 = 1; id_rs1 = 0;
    #1 check("lu_rd0", 32'(pc_stall), 32'd0);
    cycle();

    // mem_busy for 3 cycles with a pending redirect, then the redirect alone.
    do_reset();
    ex_valid = 1; ex_redirect = 1; mem_busy = 1;
    repeat (3) cycle();
    mem_busy = 0; cycle();
    set_idle(); cycle();
    check("mb_stall3", 32'(stall_cnt), 32'd3);
    check("mb_flush1", 32'(flush_cnt), 32'd1);

    // Trap, full sequence; then trap restarted during drain.
    trap = 1; cycle(); trap = 0;
    repeat (5) cycle();
    trap = 1; cycle(); trap = 0;
    repeat (2) cycle();
    trap = 1; cycle(); trap = 0;
    repeat (6) cycle();
    check("trap_flush_cnt", 32'(flush_cnt), 32'd4);

    // CSR serialization behind a valid MEM instruction.
    id_valid = 1; id_is_csr = 1; mem_valid = 1;
    repeat (3) cycle();
    mem_valid = 0;
    #1 check("csr_release", 32'(pc_stall), 32'd0);
    cycle();

    // Stall counter wrap: 17 stall cycles on a 4-bit counter.
    do_reset();
    ex_busy = 1;
    repeat (17) cycle();
    set_idle();
    #1 check("wrap", 32'(stall_cnt), 32'd1);
    cycle();

    // Reset in the middle of drain.
    trap = 1; cycle(); trap = 0; cycle(); cycle();
    rst = 1; cycle(); rst = 0;
    #1 check("rst_drain_busy", 32'(trap_busy), 32'd0);
    check("rst_drain_fcnt", 32'(flush_cnt), 32'd0);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 59) == 0);
      trap        = ($urandom_range(0, 24) == 0);
      mem_busy    = ($urandom_range(0, 5) == 0);
      ex_busy     = ($urandom_range(0, 5) == 0);
      ex_redirect = ($urandom_range(0, 4) == 0);
      ex_valid    = 1'($urandom);
      ex_is_load  = 1'($urandom);
      ex_rd       = 5'($urandom_range(0, 3));
      id_valid    = 1'($urandom);
      id_uses_rs1 = 1'($urandom);
      id_uses_rs2 = 1'($urandom);
      id_rs1      = 5'($urandom_range(0, 3));
      id_rs2      = 5'($urandom_range(0, 3));
      id_is_csr   = ($urandom_range(0, 3) == 0);
      mem_valid   = 1'($urandom);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
